// File: rtl/alu_op_driver.sv
// ---------------------------------------------------------------------------
// alu_op_driver
//
// Stimulus-and-capture driver for the four-operation register ALU (sum,
// difference, AND, OR). Operand pairs arrive on a valid/ready command port
// and are queued in a small FIFO. One command is in flight at a time:
//   - the operands are driven to the ALU with a one-cycle start strobe,
//   - the driver waits LAT cycles,
//   - it samples the four ALU result registers once,
//   - it compares them with values computed locally from the same operands.
// The captured results are held on a valid/ready result port until accepted.
//
// Parameters:
//   WIDTH  operand/result width
//   DEPTH  command FIFO entries (power of two, >= 2)
//   LAT    ALU register latency in cycles (>= 1)
//
// Ports:
//   clk                              rising-edge clock
//   rst                              synchronous active-low reset
//   cmd_valid / cmd_ready            command handshake (ready = FIFO not full)
//   cmd_a, cmd_b                     command operands
//   alu_a, alu_b                     registered operands to the ALU
//   alu_start                        one-cycle strobe, operands valid
//   plus_in, mins_in, and_in, or_in  ALU result registers
//   res_valid / res_ready            result handshake
//   res_plus, res_mins, res_and,
//   res_or                           captured (observed) ALU results
//   err_pulse                        one-cycle mismatch flag at capture
//   err_cnt                          saturating mismatch count
// ---------------------------------------------------------------------------
module alu_op_driver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_start,
    input  logic [WIDTH-1:0] plus_in,
    input  logic [WIDTH-1:0] mins_in,
    input  logic [WIDTH-1:0] and_in,
    input  logic [WIDTH-1:0] or_in,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_plus,
    output logic [WIDTH-1:0] res_mins,
    output logic [WIDTH-1:0] res_and,
    output logic [WIDTH-1:0] res_or,

    output logic             err_pulse,
    output logic [15:0]      err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + 1);

    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_LAT = CW'(LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // Pointers carry one extra wrap bit so full and empty are told apart
    // without a separate occupancy counter.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    state_t           state;
    logic [CW-1:0]    wait_cnt;
    logic [WIDTH-1:0] exp_plus;
    logic [WIDTH-1:0] exp_mins;
    logic [WIDTH-1:0] exp_and;
    logic [WIDTH-1:0] exp_or;
    logic             mismatch;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Ready depends only on registered pointers. A pop in the same cycle
    // does not make room for a push that was offered while full.
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == S_IDLE) && !empty;

    assign head_a = mem_a[rd_ptr[AW-1:0]];
    assign head_b = mem_b[rd_ptr[AW-1:0]];

    // NOTE: the storage array is left out of reset on purpose. Only the
    // entries between rd_ptr and wr_ptr are ever read, and the pointers are
    // reset, so stale contents can never become visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]] <= cmd_a;
            mem_b[wr_ptr[AW-1:0]] <= cmd_b;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments, so each
    // register samples values from before the edge regardless of the
    // order in which the blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Any field differing from the locally computed value counts as one
    // mismatch. The comparison is only consumed on the capture cycle.
    assign mismatch = (plus_in != exp_plus) || (mins_in != exp_mins) ||
                      (and_in  != exp_and)  || (or_in   != exp_or);

    // ------------------------------------------------------------------
    // Sequencer: pop -> drive -> wait LAT -> capture -> hold until taken
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_start <= 1'b0;
            exp_plus  <= '0;
            exp_mins  <= '0;
            exp_and   <= '0;
            exp_or    <= '0;
            res_valid <= 1'b0;
            res_plus  <= '0;
            res_mins  <= '0;
            res_and   <= '0;
            res_or    <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        alu_a     <= head_a;
                        alu_b     <= head_b;
                        alu_start <= 1'b1;
                        // Expected values are latched together with the
                        // operands; sum and difference wrap modulo 2^WIDTH.
                        exp_plus  <= head_a + head_b;
                        exp_mins  <= head_a - head_b;
                        exp_and   <= head_a & head_b;
                        exp_or    <= head_a | head_b;
                        state     <= S_DRIVE;
                    end
                end

                S_DRIVE: begin
                    alu_start <= 1'b0;
                    wait_cnt  <= CNT_LAT;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_ONE;
                    // The counter reaching zero on this edge is the single
                    // sampling point; later ALU activity is ignored.
                    if (wait_cnt == CNT_ONE) begin
                        res_plus  <= plus_in;
                        res_mins  <= mins_in;
                        res_and   <= and_in;
                        res_or    <= or_in;
                        res_valid <= 1'b1;
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                        end
                        state <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_op_driver
//
// Self-checking bench for alu_op_driver. Contains:
//   - an ALU model that registers results one cycle after alu_start and
//     drives random junk otherwise, with optional single-field corruption;
//   - a timestamp-based reference model of the driver that predicts every
//     output on every cycle from accept/start/capture/release times;
//   - a directed sequence with hand-computed expectations, followed by a
//     randomized phase.
// ---------------------------------------------------------------------------
module tb_alu_op_driver;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic             alu_start;
    logic [WIDTH-1:0] plus_in, mins_in, and_in, or_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_plus, res_mins, res_and, res_or;
    logic             err_pulse;
    logic [15:0]      err_cnt;

    logic [2:0]       inj;   // 0: correct ALU, 1..4: corrupt one field

    always #5 clk = ~clk;

    alu_op_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_start (alu_start),
        .plus_in   (plus_in),
        .mins_in   (mins_in),
        .and_in    (and_in),
        .or_in     (or_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_plus  (res_plus),
        .res_mins  (res_mins),
        .res_and   (res_and),
        .res_or    (res_or),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    // ------------------------------------------------------------------
    // ALU model: result registers load on the edge that sees alu_start,
    // and carry junk on every other edge so a mistimed capture shows up.
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        if (alu_start) begin
            plus_in <= alu_a + alu_b + ((inj == 3'd1) ? 8'd1 : 8'd0);
            mins_in <= alu_a - alu_b + ((inj == 3'd2) ? 8'd1 : 8'd0);
            and_in  <= (alu_a & alu_b) ^ ((inj == 3'd3) ? 8'h01 : 8'h00);
            or_in   <= (alu_a | alu_b) ^ ((inj == 3'd4) ? 8'h80 : 8'h00);
        end else begin
            plus_in <= 8'($urandom);
            mins_in <= 8'($urandom);
            and_in  <= 8'($urandom);
            or_in   <= 8'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                      name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model. Each accepted command gets timestamps: it starts on
    // the first edge after both its accept edge and the previous result's
    // release edge, is captured 1+LAT edges after starting, and is released
    // on the first later edge with res_ready high.
    // ------------------------------------------------------------------
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t             q[$];
    cmd_t             cur;
    int               cyc   = 0;
    int               rel_c = 0;
    int               cap_c = 0;
    bit               busy  = 1'b0;
    bit               acc;
    bit               model_ok = 1'b0;

    logic             m_cmd_ready = 1'b1;
    logic [WIDTH-1:0] m_alu_a = '0, m_alu_b = '0;
    logic             m_alu_start = 1'b0;
    logic             m_res_valid = 1'b0;
    logic [WIDTH-1:0] m_res_plus = '0, m_res_mins = '0;
    logic [WIDTH-1:0] m_res_and = '0, m_res_or = '0;
    logic             m_err_pulse = 1'b0;
    logic [15:0]      m_err_cnt = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            q.delete();
            busy        = 1'b0;
            rel_c       = cyc;
            m_alu_a     = '0;
            m_alu_b     = '0;
            m_alu_start = 1'b0;
            m_res_valid = 1'b0;
            m_res_plus  = '0;
            m_res_mins  = '0;
            m_res_and   = '0;
            m_res_or    = '0;
            m_err_pulse = 1'b0;
            m_err_cnt   = '0;
        end else begin
            acc         = cmd_valid && (q.size() < DEPTH);
            m_alu_start = 1'b0;
            m_err_pulse = 1'b0;
            if (busy && cyc > cap_c && res_ready) begin
                busy        = 1'b0;
                rel_c       = cyc;
                m_res_valid = 1'b0;
            end
            if (!busy && q.size() > 0 && cyc > rel_c) begin
                cur         = q.pop_front();
                busy        = 1'b1;
                cap_c       = cyc + 1 + LAT;
                m_alu_a     = cur.a;
                m_alu_b     = cur.b;
                m_alu_start = 1'b1;
            end
            if (busy && cyc == cap_c) begin
                m_res_plus  = plus_in;
                m_res_mins  = mins_in;
                m_res_and   = and_in;
                m_res_or    = or_in;
                m_res_valid = 1'b1;
                if (plus_in != 8'(cur.a + cur.b) || mins_in != 8'(cur.a - cur.b) ||
                    and_in != (cur.a & cur.b) || or_in != (cur.a | cur.b)) begin
                    m_err_pulse = 1'b1;
                    if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
                end
            end
            if (acc) q.push_back('{a: cmd_a, b: cmd_b});
        end
        m_cmd_ready = (q.size() < DEPTH);
        model_ok    = 1'b1;
    end

    // Compare every output on every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("cmd_ready", 32'(cmd_ready), 32'(m_cmd_ready));
            check("alu_a",     32'(alu_a),     32'(m_alu_a));
            check("alu_b",     32'(alu_b),     32'(m_alu_b));
            check("alu_start", 32'(alu_start), 32'(m_alu_start));
            check("res_valid", 32'(res_valid), 32'(m_res_valid));
            check("res_plus",  32'(res_plus),  32'(m_res_plus));
            check("res_mins",  32'(res_mins),  32'(m_res_mins));
            check("res_and",   32'(res_and),   32'(m_res_and));
            check("res_or",    32'(res_or),    32'(m_res_or));
            check("err_pulse", 32'(err_pulse), 32'(m_err_pulse));
            check("err_cnt",   32'(err_cnt),   32'(m_err_cnt));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // ------------------------------------------------------------------
    // Offer one command until accepted; returns at the falling edge after
    // the accepting rising edge.
    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok = 1'b0;
        bit r;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            r = cmd_ready;
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    // Advance falling edges until res_valid is seen.
    task automatic wait_res(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    logic [WIDTH-1:0] ra [6];
    logic [WIDTH-1:0] rb [6];
    logic [WIDTH-1:0] acc_a [$];
    logic [WIDTH-1:0] acc_b [$];
    logic [WIDTH-1:0] snap_plus, snap_mins;
    int               n_acc;
    bit               r_now;
    bit               saw_valid;

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b1;
        inj       = 3'd0;

        // ---- Reset: two edges low, then release --------------------------
        repeat (2) @(negedge clk);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_b",     32'(alu_b),     32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_plus",  32'(res_plus),  32'd0);
        check("rst_res_or",    32'(res_or),    32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_no_start",  32'(alu_start), 32'd0);

        // ---- Nominal 36, 12 ----------------------------------------------
        push(8'd36, 8'd12);
        @(negedge clk);
        check("nom_start_hi", 32'(alu_start), 32'd1);
        check("nom_alu_a",    32'(alu_a),     32'd36);
        check("nom_alu_b",    32'(alu_b),     32'd12);
        @(negedge clk);
        check("nom_start_lo", 32'(alu_start), 32'd0);
        check("nom_valid_lo", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("nom_valid_hi", 32'(res_valid), 32'd1);
        check("nom_plus",     32'(res_plus),  32'd48);
        check("nom_mins",     32'(res_mins),  32'd24);
        check("nom_and",      32'(res_and),   32'd4);
        check("nom_or",       32'(res_or),    32'd44);
        check("nom_err_cnt",  32'(err_cnt),   32'd0);
        check("nom_err_p",    32'(err_pulse), 32'd0);

        // ---- Wrap-around -------------------------------------------------
        push(8'd5, 8'd10);
        wait_res("wrap1_res");
        check("wrap_mins", 32'(res_mins), 32'd251);
        push(8'd200, 8'd100);
        wait_res("wrap2_res");
        check("wrap_plus",    32'(res_plus), 32'd44);
        check("wrap_err_cnt", 32'(err_cnt),  32'd0);

        // ---- Mismatch: ALU returns plus+1 --------------------------------
        inj = 3'd1;
        push(8'd36, 8'd12);
        wait_res("mis1_res");
        check("mis_plus",     32'(res_plus),  32'd49);
        check("mis_err_p",    32'(err_pulse), 32'd1);
        check("mis_err_cnt1", 32'(err_cnt),   32'd1);
        @(negedge clk);
        check("mis_err_p_lo", 32'(err_pulse), 32'd0);
        push(8'd36, 8'd12);
        wait_res("mis2_res");
        check("mis_err_cnt2", 32'(err_cnt), 32'd2);
        inj = 3'd0;
        repeat (3) @(negedge clk);

        // ---- Backpressure / full -----------------------------------------
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ra[i] = 8'($urandom);
            rb[i] = 8'($urandom);
        end
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = ra[i];
            cmd_b     = rb[i];
            r_now     = cmd_ready;
            @(negedge clk);
            if (r_now) begin
                n_acc++;
                acc_a.push_back(ra[i]);
                acc_b.push_back(rb[i]);
            end
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(n_acc),     32'd5);
        check("bp_full",     32'(cmd_ready), 32'd0);
        check("bp_valid",    32'(res_valid), 32'd1);
        snap_plus = res_plus;
        snap_mins = res_mins;
        repeat (6) @(negedge clk);
        check("bp_hold_plus", 32'(res_plus),  32'(snap_plus));
        check("bp_hold_mins", 32'(res_mins),  32'(snap_mins));
        check("bp_hold_vld",  32'(res_valid), 32'd1);
        check("bp_first",     32'(res_plus),  32'(8'(acc_a[0] + acc_b[0])));
        res_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            wait_res("bp_res");
            if (k < acc_a.size()) begin
                check("bp_order_plus", 32'(res_plus), 32'(8'(acc_a[k] + acc_b[k])));
                check("bp_order_mins", 32'(res_mins), 32'(8'(acc_a[k] - acc_b[k])));
            end
        end
        repeat (3) @(negedge clk);

        // ---- Reset mid-operation -----------------------------------------
        push(8'd1, 8'd2);
        push(8'd3, 8'd4);
        push(8'd5, 8'd6);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) saw_valid = 1'b1;
        end
        check("mid_no_valid",  32'(saw_valid), 32'd0);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_err_cnt",   32'(err_cnt),   32'd0);
        push(8'd36, 8'd12);
        wait_res("mid_fresh_res");
        check("mid_fresh_plus", 32'(res_plus), 32'd48);

        // ---- Randomized traffic ------------------------------------------
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) != 0);
            cmd_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       cmd_a = 8'h00;
                1:       cmd_a = 8'hFF;
                default: cmd_a = 8'($urandom);
            endcase
            cmd_b     = 8'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            inj       = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
            @(negedge clk);
        end

        // ---- Drain -------------------------------------------------------
        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        inj       = 3'd0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

Hardware stimulus-and-capture driver for the four-operation register ALU block, which produces sum, difference, bitwise AND and bitwise OR registers. It accepts operand pairs through a valid/ready command port and queues them in a small FIFO. For each pair it drives the ALU operands, waits a fixed ALU latency, and captures the four result registers. It checks each captured result against an internally computed expected value and presents it on a valid/ready result port. The block sits between a command source (bench or on-chip sequencer) and the ALU, and serves as the driving end that our response checks currently sample.

## Interface
- WIDTH, 8, operand/result width
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- LAT, 1, ALU register latency in cycles (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low (0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept
- cmd_a, cmd_b  in  WIDTH  operands
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_start  out  1  one-cycle strobe, operands valid
- plus_in, mins_in, and_in, or_in  in  WIDTH  ALU result registers
- res_valid  out  1  captured result held
- res_ready  in  1  consumer accepts
- res_plus, res_mins, res_and, res_or  out  WIDTH  captured results (observed, not expected)
- err_pulse  out  1  one-cycle mismatch flag at capture
- err_cnt  out  16  saturating mismatch count

## Operation
- Push on cmd_valid && cmd_ready. cmd_ready = !full, registered-state based. A push while full is refused, with no lookahead from a simultaneous pop.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, register alu_a/alu_b, set alu_start=1, go to DRIVE.
  - DRIVE (1 cycle): alu_start→0, load wait counter with LAT, go to WAIT.
  - WAIT: decrement; at 0 capture plus_in/mins_in/and_in/or_in into res_*, set res_valid=1, evaluate check, go to HOLD.
  - HOLD: on res_valid && res_ready, clear res_valid and go to IDLE.
- Expected values are latched with the operands:
  - plus = (a+b) mod 2^WIDTH
  - mins = (a−b) mod 2^WIDTH (two's-complement wrap)
  - and = a&b
  - or = a|b
- Check: if any captured field ≠ expected, err_pulse=1 for exactly the capture cycle and err_cnt increments. err_cnt saturates at 0xFFFF.
- alu_a/alu_b hold their last values between commands.
- Commands are processed strictly in order, one in flight. The FIFO keeps accepting while the FSM is busy.

## Timing
- Reset (rst=0 at a rising edge):
  - Outputs: alu_a, alu_b, alu_start, res_*, res_valid, err_pulse and err_cnt all go to 0.
  - State: FIFO emptied, FSM to IDLE. cmd_ready=1 once rst=1.
- Reset mid-operation (DRIVE/WAIT/HOLD) discards the in-flight command and all queued commands. No res_valid follows.
- Accept at edge A with FSM idle and FIFO empty:
  - alu_start rises at edge A+1 and falls at A+2.
  - Capture occurs at edge A+2+LAT; res_valid is high from then. With LAT=1, res_valid rises 3 edges after accept.
- Back-to-back throughput: with res_ready=1 held, HOLD lasts 1 cycle. The next alu_start rises at the edge after HOLD exits through IDLE, giving LAT+3 cycles per command.
- res_* are stable while res_valid=1 and res_ready=0.
- Capture is a single sample. ALU activity after the capture edge is ignored.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release. All outputs are 0, cmd_ready=1, and no alu_start occurs with the FIFO empty.
- Nominal (LAT=1, correct ALU model): push a=36, b=12.
  - alu_a=36 and alu_b=12, with alu_start high for exactly 1 cycle.
  - res_valid rises 3 edges after accept with res_plus=48, res_mins=24, res_and=4, res_or=44.
  - err_cnt=0 and err_pulse never asserts.
- Wrap-around: push a=5,b=10 then a=200,b=100. Expect res_mins=251, then res_plus=44, and err_cnt=0.
- Mismatch: the ALU model returns plus+1 for a=36,b=12. Expect res_plus=49, err_pulse high for 1 cycle at capture, and err_cnt=1. Repeat the same command to get err_cnt=2.
- Backpressure/full (DEPTH=4): hold res_ready=0 and offer 6 commands.
  - Exactly 5 are accepted (1 in flight, 4 queued), and cmd_ready=0 afterwards.
  - res_* hold stable while stalled.
  - After releasing res_ready, the 5 results emerge in order and cmd_ready returns high after the first pop.
- Reset mid-op: assert rst=0 during WAIT with 2 commands queued. Expect res_valid never asserts, cmd_ready=1, err_cnt=0, and a fresh command afterwards completes normally.
